// File: rtl/riscv_mem_pkg.sv
// Shared decode constants and types for the data-memory / MMIO responder.
package riscv_mem_pkg;

  localparam logic [15:0] MMIO_PAGE    = 16'hFFFF;

  localparam logic [15:0] OFF_TXDATA   = 16'h0000;
  localparam logic [15:0] OFF_STATUS   = 16'h0004;
  localparam logic [15:0] OFF_MTIME    = 16'h0008;
  localparam logic [15:0] OFF_MTIMECMP = 16'h000C;

  // STATUS register bit positions
  localparam int unsigned ST_IRQ   = 0;
  localparam int unsigned ST_EMPTY = 1;
  localparam int unsigned ST_FULL  = 2;
  localparam int unsigned ST_OVF   = 3;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_TXDATA,
    SEL_STATUS,
    SEL_MTIME,
    SEL_MTIMECMP,
    SEL_NONE
  } mmio_sel_e;

  // Address bits [1:0] never take part in decode.
  function automatic mmio_sel_e decode_sel(input logic [31:0] addr);
    mmio_sel_e   sel;
    logic [15:0] off;
    off = {addr[15:2], 2'b00};
    sel = SEL_NONE;
    if (addr[31:16] != MMIO_PAGE) begin
      sel = SEL_RAM;
    end else begin
      case (off)
        OFF_TXDATA:   sel = SEL_TXDATA;
        OFF_STATUS:   sel = SEL_STATUS;
        OFF_MTIME:    sel = SEL_MTIME;
        OFF_MTIMECMP: sel = SEL_MTIMECMP;
        default:      sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/dmem_mmio_responder_if.sv
// Core data-memory port plus console byte-sink handshake and interrupt line.
interface dmem_mmio_responder_if;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        irq;

  // Core and byte sink side
  modport master (
    output MemWrite, Addr, WriteData, tx_ready,
    input  ReadData, tx_data, tx_valid, irq
  );

  // Responder side
  modport slave (
    input  MemWrite, Addr, WriteData, tx_ready,
    output ReadData, tx_data, tx_valid, irq
  );
endinterface

// File: rtl/tx_fifo.sv
// Console TX byte FIFO. A push while full is only accepted when a pop happens in the
// same cycle; head reads zero when empty.
module tx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  output logic                         full_o,
  input  logic                         pop_i,
  output logic                         empty_o,
  output logic [WIDTH-1:0]             head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = empty_o ? '0 : storage[rptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy next state; pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + PW'(1);
    if (do_pop)  rptr_d = rptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Byte storage, not reset
  always_ff @(posedge clk_i) begin
    if (do_push) storage[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-port responder: word RAM plus MMIO page (console TX FIFO, STATUS, optional timer).
// Optional timer built when MMIO_TIMER_EN is defined.
module dmem_mmio_responder
  import riscv_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 64,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_mmio_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  mmio_sel_e   sel;
  logic [AW-1:0] ram_idx;
  logic [31:0] mem [MEM_WORDS];
  logic [31:0] status_rd;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_drop;
  logic [CW-1:0] fifo_count;
  logic          ovf_q, ovf_d;
  logic          irq_pend;
  logic          status_wr;

  assign sel       = decode_sel(bus.Addr);
  assign ram_idx   = bus.Addr[AW+1:2];
  assign status_wr = bus.MemWrite && (sel == SEL_STATUS);

  assign fifo_push = bus.MemWrite && (sel == SEL_TXDATA);
  assign fifo_pop  = bus.tx_valid && bus.tx_ready;
  // A push into a full FIFO survives only when a pop frees a slot the same cycle
  assign fifo_drop = fifo_push && (fifo_count == CW'(FIFO_DEPTH)) && !fifo_pop;

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (fifo_push),
    .wdata_i (bus.WriteData[7:0]),
    .full_o  (fifo_full),
    .pop_i   (fifo_pop),
    .empty_o (fifo_empty),
    .head_o  (bus.tx_data),
    .count_o (fifo_count)
  );

  assign bus.tx_valid = !fifo_empty;

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (bus.MemWrite && (sel == SEL_RAM)) mem[ram_idx] <= bus.WriteData;
  end

  // Overflow flag: W1C, hardware set wins a same-cycle clear
  always_comb begin
    ovf_d = ovf_q;
    if (status_wr && bus.WriteData[ST_OVF]) ovf_d = 1'b0;
    if (fifo_drop) ovf_d = 1'b1;
  end

  // Overflow flag register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

`ifdef MMIO_TIMER_EN
  logic [31:0] mtime_q, mtime_d;
  logic [31:0] mtimecmp_q, mtimecmp_d;
  logic        irq_pend_q, irq_pend_d;

  // Timer next state; a software load of MTIME replaces that cycle's increment
  always_comb begin
    mtime_d    = mtime_q + 32'd1;
    mtimecmp_d = mtimecmp_q;
    irq_pend_d = irq_pend_q;
    if (bus.MemWrite && (sel == SEL_MTIME))    mtime_d    = bus.WriteData;
    if (bus.MemWrite && (sel == SEL_MTIMECMP)) mtimecmp_d = bus.WriteData;
    if (status_wr && bus.WriteData[ST_IRQ])    irq_pend_d = 1'b0;
    if (mtime_q == mtimecmp_q)                 irq_pend_d = 1'b1;
  end

  // Timer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mtime_q    <= '0;
      mtimecmp_q <= 32'hFFFF_FFFF;
      irq_pend_q <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  assign irq_pend = irq_pend_q;
`else
  assign irq_pend = 1'b0;
`endif

  assign bus.irq = irq_pend;
  assign status_rd = {28'b0, ovf_q, fifo_full, fifo_empty, irq_pend};

  // Zero-latency load mux
  always_comb begin
    bus.ReadData = '0;
    unique case (sel)
      SEL_RAM:      bus.ReadData = mem[ram_idx];
      SEL_STATUS:   bus.ReadData = status_rd;
`ifdef MMIO_TIMER_EN
      SEL_MTIME:    bus.ReadData = mtime_q;
      SEL_MTIMECMP: bus.ReadData = mtimecmp_q;
`endif
      default:      bus.ReadData = '0;
    endcase
  end

endmodule
